// File: rtl/frame_sif_pkg.sv
// Shared types, error codes and frame field helpers for the frame-to-register-access bridge.
package frame_sif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_SEL = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  localparam int OP_ID_LSB = 0;
  localparam int WDATA_LSB = 8;

  function automatic int f_wr_rd_bit(input int w_width);
    return w_width + 8;
  endfunction

  function automatic int f_addr_lsb(input int w_width);
    return w_width + 9;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sif_sync_fifo.sv
// Synchronous FIFO with an extra wrap bit on each pointer to tell full from empty.
module sif_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/frame_sif_hs.sv
// Frame-to-register-access bridge: buffers frames, issues one access at a time to the
// one-hot selected switch instance, waits for its ack or a timeout, returns a tagged response.
module frame_sif_hs
  import frame_sif_pkg::*;
#(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int ADDR_W      = 5,
  parameter int FRAME_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_frame_valid,
  output logic                           o_frame_ready,
  input  logic [FRAME_WIDTH-1:0]         i_frame_in,
  input  logic [NUM_SW_INST-1:0]         i_load_in,
  output logic [NUM_SW_INST-1:0]         o_sel_en,
  output logic [7:0]                     o_addr,
  output logic [W_WIDTH-1:0]             o_wr_data,
  output logic                           o_wr_rd_s,
  output logic [7:0]                     o_op_id,
  output logic                           o_req_valid,
  input  logic [NUM_SW_INST-1:0]         i_rsp_ack,
  input  logic [NUM_SW_INST*W_WIDTH-1:0] i_rsp_rd_data,
  output logic                           o_rsp_valid,
  output logic [7:0]                     o_rsp_op_id,
  output logic [W_WIDTH-1:0]             o_rsp_data,
  output logic [1:0]                     o_rsp_err,
  output logic [1:0]                     o_dbg_state
);

  localparam int ADDR_LSB = f_addr_lsb(W_WIDTH);
  localparam int WRRD_BIT = f_wr_rd_bit(W_WIDTH);
  localparam int USED_W   = ADDR_LSB + ADDR_W;
  localparam int ENTRY_W  = NUM_SW_INST + USED_W;
  localparam int TW       = $clog2(TIMEOUT + 1);

  state_t                 r_state, w_state_nxt;
  logic                   r_init;
  logic [NUM_SW_INST-1:0] r_load;
  logic [7:0]             r_addr;
  logic [W_WIDTH-1:0]     r_wdata;
  logic                   r_wr;
  logic [7:0]             r_op_id;
  logic [TW-1:0]          r_timer;
  logic [7:0]             r_rsp_op_id;
  logic [W_WIDTH-1:0]     r_rsp_data;
  logic [1:0]             r_rsp_err;

  logic                   w_push, w_pop, w_full, w_empty;
  logic [ENTRY_W-1:0]     w_fifo_dout;
  logic [NUM_SW_INST-1:0] w_pop_load;
  logic                   w_pop_onehot;
  logic                   w_sel_ack;
  logic [TW-1:0]          w_timer_inc;
  logic                   w_timeout;
  logic [W_WIDTH-1:0]     w_sel_rdata;

  // Bits above the addr field carry nothing for this bridge.
  generate
    if (FRAME_WIDTH > USED_W) begin : g_unused
      logic w_unused_upper;
      assign w_unused_upper = ^i_frame_in[FRAME_WIDTH-1:USED_W];
    end
  endgenerate

  // frame_ready stays low until the first clock after reset release.
  assign o_frame_ready = r_init & ~w_full;
  assign w_push        = i_frame_valid & o_frame_ready;
  assign w_pop         = (r_state == IDLE) & ~w_empty;

  sif_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({i_load_in, i_frame_in[USED_W-1:0]}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop_load   = w_fifo_dout[USED_W +: NUM_SW_INST];
  assign w_pop_onehot = is_onehot(32'(w_pop_load));
  assign w_sel_ack    = |(i_rsp_ack & r_load);
  assign w_timer_inc  = r_timer + TW'(1);
  assign w_timeout    = (w_timer_inc == TW'(TIMEOUT));

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (r_load[i]) w_sel_rdata = w_sel_rdata | i_rsp_rd_data[i*W_WIDTH +: W_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_init  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_init  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (!w_empty) w_state_nxt = w_pop_onehot ? ISSUE : RESP;
      ISSUE: w_state_nxt = WAIT;
      WAIT:  if (w_sel_ack || w_timeout) w_state_nxt = RESP;
      RESP:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_req_valid = (r_state == ISSUE);
    o_rsp_valid = (r_state == RESP);
    o_sel_en    = ((r_state == ISSUE) || (r_state == WAIT)) ? r_load : '0;
    o_dbg_state = r_state;
    o_addr      = r_addr;
    o_wr_data   = r_wdata;
    o_wr_rd_s   = r_wr;
    o_op_id     = r_op_id;
    o_rsp_op_id = r_rsp_op_id;
    o_rsp_data  = r_rsp_data;
    o_rsp_err   = r_rsp_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr        <= 1'b0;
      r_op_id     <= '0;
      r_timer     <= '0;
      r_rsp_op_id <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= ERR_OK;
    end else begin
      if (w_pop) begin
        r_load  <= w_pop_load;
        r_addr  <= 8'(w_fifo_dout[ADDR_LSB +: ADDR_W]);
        r_wdata <= w_fifo_dout[WDATA_LSB +: W_WIDTH];
        r_wr    <= w_fifo_dout[WRRD_BIT];
        r_op_id <= w_fifo_dout[OP_ID_LSB +: 8];
      end
      if (r_state == ISSUE)                  r_timer <= '0;
      else if (r_state == WAIT && !w_sel_ack) r_timer <= w_timer_inc;
      // Response fields update only on entry to RESP so they hold between strobes.
      if (w_pop && !w_pop_onehot) begin
        r_rsp_op_id <= w_fifo_dout[OP_ID_LSB +: 8];
        r_rsp_data  <= '0;
        r_rsp_err   <= ERR_SEL;
      end else if (r_state == WAIT && w_sel_ack) begin
        r_rsp_op_id <= r_op_id;
        r_rsp_data  <= r_wr ? '0 : w_sel_rdata;
        r_rsp_err   <= ERR_OK;
      end else if (r_state == WAIT && w_timeout) begin
        r_rsp_op_id <= r_op_id;
        r_rsp_data  <= '0;
        r_rsp_err   <= ERR_TMO;
      end
    end
  end

endmodule

// File: tb/tb_frame_sif_hs.sv
// Directed bench for frame_sif_hs: single access, read, timeout, bad select,
// backpressure ordering and reset mid-access.
module tb_frame_sif_hs;
  import frame_sif_pkg::*;

  localparam int NSW = 5;
  localparam int W   = 8;
  localparam int FW  = 32;
  localparam int TMO = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           frame_valid;
  logic           frame_ready;
  logic [FW-1:0]  frame_in;
  logic [NSW-1:0] load_in;
  logic [NSW-1:0] sel_en;
  logic [7:0]     addr;
  logic [W-1:0]   wr_data;
  logic           wr_rd_s;
  logic [7:0]     op_id;
  logic           req_valid;
  logic [NSW-1:0] rsp_ack;
  logic [NSW-1:0] man_ack;
  logic [NSW-1:0] auto_ack;
  logic [NSW*W-1:0] rsp_rd_data;
  logic           rsp_valid;
  logic [7:0]     rsp_op_id;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_err;
  logic [1:0]     dbg_state;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int rsp_cnt = 0;
  logic auto_en = 1'b0;
  int ack_delay = 4;
  int ack_cnt = 0;
  logic [NSW-1:0] ack_tgt = '0;
  logic [17:0] obs_log [64];
  logic [17:0] exp_q [$];

  always #5 clk = ~clk;
  assign rsp_ack = man_ack | auto_ack;

  frame_sif_hs dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_valid (frame_valid),
    .o_frame_ready (frame_ready),
    .i_frame_in    (frame_in),
    .i_load_in     (load_in),
    .o_sel_en      (sel_en),
    .o_addr        (addr),
    .o_wr_data     (wr_data),
    .o_wr_rd_s     (wr_rd_s),
    .o_op_id       (op_id),
    .o_req_valid   (req_valid),
    .i_rsp_ack     (rsp_ack),
    .i_rsp_rd_data (rsp_rd_data),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_op_id   (rsp_op_id),
    .o_rsp_data    (rsp_data),
    .o_rsp_err     (rsp_err),
    .o_dbg_state   (dbg_state)
  );

  // Strobe log, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid) req_cnt++;
      if (rsp_valid) begin
        obs_log[rsp_cnt[5:0]] = {rsp_op_id, rsp_data, rsp_err};
        rsp_cnt++;
      end
    end
  end

  // Instance model: pulses ack on the selected bit ack_delay cycles after req_valid.
  always @(negedge clk) begin
    auto_ack = '0;
    if (auto_en && rst_n) begin
      if (req_valid) begin
        ack_cnt = ack_delay;
        ack_tgt = sel_en;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) auto_ack = ack_tgt;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input logic [4:0] a, input logic wr,
                                       input logic [7:0] d, input logic [7:0] id);
    logic [9:0] junk;
    junk = 10'($urandom_range(0, 1023));
    return {junk, a, wr, d, id};
  endfunction

  // Returns one cycle after the frame was accepted; waited = stall cycles.
  task automatic push(input logic [NSW-1:0] ld, input logic [FW-1:0] fr, output int waited);
    frame_valid = 1'b1;
    load_in     = ld;
    frame_in    = fr;
    waited      = 0;
    while (!frame_ready && waited < 200) begin
      tick();
      waited++;
    end
    chk("push_accept", 32'(frame_ready), 32'd1);
    tick();
    frame_valid = 1'b0;
  endtask

  initial begin
    int n;
    int w;
    int first_stall;
    int base_req;
    int base_rsp;
    frame_valid = 1'b0;
    frame_in    = '0;
    load_in     = '0;
    man_ack     = '0;
    rsp_rd_data = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset state
    repeat (3) tick();
    chk("rst_ready", 32'(frame_ready), 32'd0);
    chk("rst_sel_en", 32'(sel_en), 32'd0);
    chk("rst_req", 32'(req_valid), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    chk("ready_before_clk", 32'(frame_ready), 32'd0);
    tick();
    chk("ready_after_clk", 32'(frame_ready), 32'd1);

    // 1: single write, ack 3 cycles after req
    push(5'b00100, mk(5'h0A, 1'b1, 8'h5A, 8'h01), w);
    chk("t1_req_early", 32'(req_valid), 32'd0);
    tick();
    chk("t1_req", 32'(req_valid), 32'd1);
    chk("t1_sel", 32'(sel_en), 32'h04);
    chk("t1_addr", 32'(addr), 32'h0A);
    chk("t1_wdata", 32'(wr_data), 32'h5A);
    chk("t1_wr", 32'(wr_rd_s), 32'd1);
    chk("t1_opid", 32'(op_id), 32'h01);
    repeat (3) tick();
    chk("t1_wait_state", 32'(dbg_state), 32'(WAIT));
    chk("t1_wait_sel", 32'(sel_en), 32'h04);
    man_ack = 5'b00100;
    tick();
    man_ack = '0;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp", 32'({rsp_op_id, rsp_data, rsp_err}), 32'({8'h01, 8'h00, 2'b00}));
    tick();
    chk("t1_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("t1_sel_clr", 32'(sel_en), 32'd0);
    chk("t1_rsp_hold", 32'(rsp_op_id), 32'h01);
    chk("t1_addr_hold", 32'(addr), 32'h0A);

    // 2: read with an ack during ISSUE that must be ignored
    rsp_rd_data[7:0] = 8'hC3;
    push(5'b00001, mk(5'h03, 1'b0, 8'hFF, 8'h22), w);
    tick();
    chk("t2_req", 32'(req_valid), 32'd1);
    man_ack = 5'b00001;
    tick();
    man_ack = '0;
    chk("t2_issue_ack_ignored", 32'(dbg_state), 32'(WAIT));
    man_ack = 5'b00001;
    tick();
    man_ack = '0;
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rsp", 32'({rsp_op_id, rsp_data, rsp_err}), 32'({8'h22, 8'hC3, 2'b00}));
    rsp_rd_data[7:0] = 8'hA0;
    tick();

    // 3: timeout, with acks on unselected bits
    push(5'b00010, mk(5'h1F, 1'b1, 8'h11, 8'h33), w);
    tick();
    chk("t3_req", 32'(req_valid), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
      man_ack = (n == 1) ? 5'b10101 : 5'b00000;
    end while (!rsp_valid && n < 100);
    man_ack = '0;
    chk("t3_latency", n, TMO + 1);
    chk("t3_rsp", 32'({rsp_op_id, rsp_data, rsp_err}), 32'({8'h33, 8'h00, 2'b10}));
    tick();

    // 4: bad selects, multi-hot then zero
    base_req = req_cnt;
    base_rsp = rsp_cnt;
    push(5'b00110, mk(5'h01, 1'b1, 8'h00, 8'h44), w);
    push(5'b00000, mk(5'h02, 1'b0, 8'h00, 8'h55), w);
    repeat (8) tick();
    chk("t4_no_req", req_cnt - base_req, 0);
    chk("t4_rsp_count", rsp_cnt - base_rsp, 2);
    chk("t4_rsp0", 32'(obs_log[base_rsp[5:0]]), 32'({8'h44, 8'h00, 2'b01}));
    chk("t4_rsp1", 32'(obs_log[6'(base_rsp + 1)]), 32'({8'h55, 8'h00, 2'b01}));
    chk("t4_sel_zero", 32'(sel_en), 32'd0);

    // 5: backpressure, six frames with delayed acks
    auto_en   = 1'b1;
    ack_delay = 4;
    base_rsp  = rsp_cnt;
    first_stall = -1;
    exp_q.push_back({8'h60, 8'hA0, 2'b00});
    exp_q.push_back({8'h61, 8'h00, 2'b00});
    exp_q.push_back({8'h62, 8'hA2, 2'b00});
    exp_q.push_back({8'h63, 8'h00, 2'b00});
    exp_q.push_back({8'h64, 8'hA4, 2'b00});
    exp_q.push_back({8'h65, 8'hA0, 2'b00});
    push(5'b00001, mk(5'h10, 1'b0, 8'h10, 8'h60), w); if (w > 0 && first_stall < 0) first_stall = 0;
    push(5'b00010, mk(5'h11, 1'b1, 8'h11, 8'h61), w); if (w > 0 && first_stall < 0) first_stall = 1;
    push(5'b00100, mk(5'h12, 1'b0, 8'h12, 8'h62), w); if (w > 0 && first_stall < 0) first_stall = 2;
    push(5'b01000, mk(5'h13, 1'b1, 8'h13, 8'h63), w); if (w > 0 && first_stall < 0) first_stall = 3;
    push(5'b10000, mk(5'h14, 1'b0, 8'h14, 8'h64), w); if (w > 0 && first_stall < 0) first_stall = 4;
    push(5'b00001, mk(5'h15, 1'b0, 8'h15, 8'h65), w); if (w > 0 && first_stall < 0) first_stall = 5;
    chk("t5_first_stall", first_stall, 5);
    n = 0;
    while ((rsp_cnt - base_rsp) < 6 && n < 300) begin
      tick();
      n++;
    end
    chk("t5_rsp_count", rsp_cnt - base_rsp, 6);
    for (int k = 0; k < 6; k++) begin
      if (exp_q.size() > 0) chk("t5_rsp_order", 32'(obs_log[6'(base_rsp + k)]), 32'(exp_q.pop_front()));
    end
    auto_en = 1'b0;
    repeat (2) tick();

    // 6: reset mid-WAIT with one frame buffered
    push(5'b01000, mk(5'h04, 1'b1, 8'h99, 8'h77), w);
    push(5'b10000, mk(5'h05, 1'b1, 8'h00, 8'h78), w);
    tick();
    chk("t6_in_wait", 32'(dbg_state), 32'(WAIT));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sel", 32'(sel_en), 32'd0);
    chk("t6_rst_rsp", 32'(rsp_valid), 32'd0);
    chk("t6_rst_ready", 32'(frame_ready), 32'd0);
    chk("t6_rst_opid", 32'(op_id), 32'd0);
    tick();
    rst_n = 1'b1;
    base_req = req_cnt;
    base_rsp = rsp_cnt;
    repeat (20) tick();
    chk("t6_dropped_req", req_cnt - base_req, 0);
    chk("t6_dropped_rsp", rsp_cnt - base_rsp, 0);
    chk("t6_ready", 32'(frame_ready), 32'd1);
    push(5'b00100, mk(5'h0A, 1'b1, 8'h5A, 8'h01), w);
    tick();
    chk("t6_req", 32'(req_valid), 32'd1);
    chk("t6_sel", 32'(sel_en), 32'h04);
    tick();
    man_ack = 5'b11011;
    tick();
    man_ack = '0;
    chk("t6_spurious_ack", 32'(rsp_valid), 32'd0);
    tick();
    chk("t6_still_wait", 32'(dbg_state), 32'(WAIT));
    man_ack = 5'b00100;
    tick();
    man_ack = '0;
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t6_rsp", 32'({rsp_op_id, rsp_data, rsp_err}), 32'({8'h01, 8'h00, 2'b00}));
    chk("t6_rsp_total", rsp_cnt - base_rsp, 1);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
